// File: rtl/rf_wb_sched.sv
// rf_wb_sched: writeback scheduler for the single register-file write port.
// Arbitrates the port between the in-order EX writeback and a long-latency
// (ll) unit, tracks outstanding ll destinations in a busy scoreboard and
// raises a decode stall on RAW/WAW hazards against those destinations.
// An ll result that loses arbitration MAX_WAIT cycles in a row forces a
// one-cycle STARVE slot in which the pipeline is held and ll owns the port.
//
// Optional feature macro: RF_WB_BYPASS_EN
//   When defined, a destination whose ll result is written this cycle no
//   longer counts as a hazard (the regfile forwards same-cycle writes).
//   When undefined, the stall persists until the busy bit clears.
//
// Handshake contract:
//   ll issue : an op is accepted on a cycle with ll_issue_valid & ll_issue_ready.
//   ll result: ll_wb_valid holds rd/data stable until the cycle with
//              ll_wb_valid & ll_wb_ready; that cycle completes the transfer.
//   ex result: no backpressure; when ex_hold is high the pipeline re-presents
//              the same writeback next cycle.
// Debug outputs expose FSM state, the busy vector and the wait counter.
module rf_wb_sched #(
   parameter int XLEN     = 32,
   parameter int MAX_WAIT = 4,
   parameter int WAIT_W   = 3
) (
   input  logic              clk,
   input  logic              rst,
   // decode hazard check
   input  logic              dec_valid,
   input  logic [4:0]        dec_rs1_addr,
   input  logic [4:0]        dec_rs2_addr,
   input  logic [4:0]        dec_rd_addr,
   output logic              hazard_stall,
   // ll issue
   input  logic              ll_issue_valid,
   input  logic [4:0]        ll_issue_rd,
   output logic              ll_issue_ready,
   // ll result
   input  logic              ll_wb_valid,
   input  logic [4:0]        ll_wb_rd,
   input  logic [XLEN-1:0]   ll_wb_data,
   output logic              ll_wb_ready,
   // pipeline writeback
   input  logic              ex_wb_valid,
   input  logic [4:0]        ex_wb_rd,
   input  logic [XLEN-1:0]   ex_wb_data,
   output logic              ex_hold,
   // regfile write port
   output logic              wr_en,
   output logic [4:0]        rd_addr_o,
   output logic [XLEN-1:0]   rd_data_o,
   // debug visibility
   output logic              o_dbg_state,
   output logic [31:0]       o_dbg_busy,
   output logic [WAIT_W-1:0] o_dbg_wait_cnt
);

   typedef enum logic {
      S_NORMAL = 1'b0,
      S_STARVE = 1'b1
   } state_t;

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [31:0]       r_busy;
   logic [31:0]       w_busy_nxt;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [WAIT_W-1:0] w_wait_nxt;
   logic              r_ex_hold;
   logic              w_ex_hold_nxt;

   logic              w_ex_grant;
   logic              w_ll_ready;
   logic              w_ll_fire;
   logic              w_issue_ready;
   logic              w_issue_fire;
   logic [31:0]       w_set_mask;
   logic [31:0]       w_clr_mask;
   logic              w_hit_rs1;
   logic              w_hit_rs2;
   logic              w_hit_rd;
   logic              w_byp_rs1;
   logic              w_byp_rs2;
   logic              w_byp_rd;
   logic              w_wr_en;
   logic [4:0]        w_wr_addr;
   logic [XLEN-1:0]   w_wr_data;

   // FSM state, pipeline hold and wait counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_NORMAL;
         r_ex_hold  <= 1'b0;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_ex_hold  <= w_ex_hold_nxt;
         r_wait_cnt <= w_wait_nxt;
      end
   end

   // Arbitration, next-state and wait-counter update
   always_comb begin
      w_state_nxt   = r_state;
      w_ex_hold_nxt = r_ex_hold;
      w_wait_nxt    = r_wait_cnt;
      w_ex_grant    = 1'b0;
      w_ll_ready    = 1'b0;
      case (r_state)
         S_NORMAL: begin
            // EX wins whenever it actually writes; a write to x0 yields to ll
            w_ex_grant = ex_wb_valid & (ex_wb_rd != 5'd0);
            w_ll_ready = ~w_ex_grant;
            if (ll_wb_valid && !w_ll_ready) begin
               if (r_wait_cnt == WAIT_LAST) begin
                  w_state_nxt   = S_STARVE;
                  w_ex_hold_nxt = 1'b1;
               end else begin
                  w_wait_nxt = r_wait_cnt + WAIT_W'(1);
               end
            end else if (ll_wb_valid && w_ll_ready) begin
               w_wait_nxt = '0;
            end
         end
         S_STARVE: begin
            // ll owns the port for exactly one cycle; EX is frozen and ignored
            w_ll_ready    = 1'b1;
            w_state_nxt   = S_NORMAL;
            w_ex_hold_nxt = 1'b0;
            w_wait_nxt    = '0;
         end
         default: begin
            w_state_nxt   = S_NORMAL;
            w_ex_hold_nxt = 1'b0;
            w_wait_nxt    = '0;
         end
      endcase
   end

   // Busy scoreboard register; x0 is never tracked
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   // Scoreboard set/clear masks; issue readiness uses the pre-clear vector
   always_comb begin
      w_ll_fire     = ll_wb_valid & w_ll_ready;
      w_issue_ready = ~r_busy[ll_issue_rd];
      w_issue_fire  = ll_issue_valid & w_issue_ready;
      w_set_mask    = '0;
      w_clr_mask    = '0;
      if (w_issue_fire && (ll_issue_rd != 5'd0)) begin
         w_set_mask[ll_issue_rd] = 1'b1;
      end
      if (w_ll_fire) begin
         w_clr_mask[ll_wb_rd] = 1'b1;
      end
      // a fresh issue takes precedence over a completion to the same register
      w_busy_nxt    = (r_busy & ~w_clr_mask) | w_set_mask;
      w_busy_nxt[0] = 1'b0;
   end

   // Decode hazard detection against outstanding ll destinations
   always_comb begin
      w_byp_rs1 = 1'b0;
      w_byp_rs2 = 1'b0;
      w_byp_rd  = 1'b0;
`ifdef RF_WB_BYPASS_EN
      // the completing ll result is forwarded by the regfile this cycle
      w_byp_rs1 = w_ll_fire & (ll_wb_rd == dec_rs1_addr);
      w_byp_rs2 = w_ll_fire & (ll_wb_rd == dec_rs2_addr);
      w_byp_rd  = w_ll_fire & (ll_wb_rd == dec_rd_addr);
`endif
      w_hit_rs1 = (dec_rs1_addr != 5'd0) & r_busy[dec_rs1_addr] & ~w_byp_rs1;
      w_hit_rs2 = (dec_rs2_addr != 5'd0) & r_busy[dec_rs2_addr] & ~w_byp_rs2;
      w_hit_rd  = (dec_rd_addr  != 5'd0) & r_busy[dec_rd_addr]  & ~w_byp_rd;
   end

   // Write-port mux: granted source drives the port, idle port reads as zero
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_addr = '0;
      w_wr_data = '0;
      if (w_ex_grant) begin
         w_wr_en   = 1'b1;
         w_wr_addr = ex_wb_rd;
         w_wr_data = ex_wb_data;
      end else if (w_ll_fire && (ll_wb_rd != 5'd0)) begin
         w_wr_en   = 1'b1;
         w_wr_addr = ll_wb_rd;
         w_wr_data = ll_wb_data;
      end
   end

   // Output gating: every combinational output reads zero while in reset
   always_comb begin
      hazard_stall   = ~rst & dec_valid & (w_hit_rs1 | w_hit_rs2 | w_hit_rd);
      ll_issue_ready = ~rst & w_issue_ready;
      ll_wb_ready    = ~rst & w_ll_ready;
      wr_en          = ~rst & w_wr_en;
      rd_addr_o      = rst ? 5'd0 : w_wr_addr;
      rd_data_o      = rst ? '0 : w_wr_data;
      ex_hold        = r_ex_hold;
      o_dbg_state    = r_state;
      o_dbg_busy     = r_busy;
      o_dbg_wait_cnt = r_wait_cnt;
   end

endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched: directed bench for rf_wb_sched (default parameters).
// Inputs change on the falling edge; outputs are sampled 1ns later, so
// combinational outputs reflect this cycle's inputs and registered outputs
// reflect the previous rising edge. Expected port writes go into exp_q when
// the step is driven and are popped when wr_en is observed.
module tb_rf_wb_sched;

   localparam int XLEN   = 32;
   localparam int WAIT_W = 3;

   logic              clk;
   logic              rst;
   logic              dec_valid;
   logic [4:0]        dec_rs1_addr;
   logic [4:0]        dec_rs2_addr;
   logic [4:0]        dec_rd_addr;
   logic              hazard_stall;
   logic              ll_issue_valid;
   logic [4:0]        ll_issue_rd;
   logic              ll_issue_ready;
   logic              ll_wb_valid;
   logic [4:0]        ll_wb_rd;
   logic [XLEN-1:0]   ll_wb_data;
   logic              ll_wb_ready;
   logic              ex_wb_valid;
   logic [4:0]        ex_wb_rd;
   logic [XLEN-1:0]   ex_wb_data;
   logic              ex_hold;
   logic              wr_en;
   logic [4:0]        rd_addr_o;
   logic [XLEN-1:0]   rd_data_o;
   logic              dbg_state;
   logic [31:0]       dbg_busy;
   logic [WAIT_W-1:0] dbg_wait_cnt;

   int checks;
   int failures;
   logic [4+XLEN:0] exp_q[$];

   rf_wb_sched #(.XLEN(XLEN), .MAX_WAIT(4), .WAIT_W(WAIT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .dec_valid      (dec_valid),
      .dec_rs1_addr   (dec_rs1_addr),
      .dec_rs2_addr   (dec_rs2_addr),
      .dec_rd_addr    (dec_rd_addr),
      .hazard_stall   (hazard_stall),
      .ll_issue_valid (ll_issue_valid),
      .ll_issue_rd    (ll_issue_rd),
      .ll_issue_ready (ll_issue_ready),
      .ll_wb_valid    (ll_wb_valid),
      .ll_wb_rd       (ll_wb_rd),
      .ll_wb_data     (ll_wb_data),
      .ll_wb_ready    (ll_wb_ready),
      .ex_wb_valid    (ex_wb_valid),
      .ex_wb_rd       (ex_wb_rd),
      .ex_wb_data     (ex_wb_data),
      .ex_hold        (ex_hold),
      .wr_en          (wr_en),
      .rd_addr_o      (rd_addr_o),
      .rd_data_o      (rd_data_o),
      .o_dbg_state    (dbg_state),
      .o_dbg_busy     (dbg_busy),
      .o_dbg_wait_cnt (dbg_wait_cnt)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      dec_valid      = 1'b0;
      dec_rs1_addr   = 5'd0;
      dec_rs2_addr   = 5'd0;
      dec_rd_addr    = 5'd0;
      ll_issue_valid = 1'b0;
      ll_issue_rd    = 5'd0;
      ll_wb_valid    = 1'b0;
      ll_wb_rd       = 5'd0;
      ll_wb_data     = '0;
      ex_wb_valid    = 1'b0;
      ex_wb_rd       = 5'd0;
      ex_wb_data     = '0;
   endtask

   // start a new cycle: move to the falling edge and clear all inputs
   task automatic next_cycle();
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic expect_write(input logic [4:0] a, input logic [XLEN-1:0] d);
      exp_q.push_back({a, d});
   endtask

   // compare the write port against the scoreboard for this cycle
   task automatic sample_port(input string tag);
      logic [4+XLEN:0] e;
      #1;
      check({tag, "_wr_en"}, wr_en, (exp_q.size() > 0) ? 1'b1 : 1'b0);
      if (wr_en && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_addr"}, rd_addr_o, e[4+XLEN:XLEN]);
         check({tag, "_data"}, rd_data_o, e[XLEN-1:0]);
      end else if (!wr_en) begin
         check({tag, "_idle_port"}, {rd_addr_o, rd_data_o}, '0);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
   endtask

   initial begin
      logic [XLEN-1:0] d;
      logic [4:0]      r;
      checks   = 0;
      failures = 0;
      idle_inputs();

      // reset state
      rst = 1'b1;
      #1;
      check("rst_busy", dbg_busy, 32'h0);
      check("rst_hold", ex_hold, 1'b0);
      check("rst_wait", dbg_wait_cnt, 3'd0);
      check("rst_state", dbg_state, 1'b0);
      next_cycle();
      next_cycle();
      rst = 1'b0;

      // issue ll to x5
      next_cycle();
      ll_issue_valid = 1'b1; ll_issue_rd = 5'd5;
      sample_port("iss5");
      check("iss5_ready", ll_issue_ready, 1'b1);
      check("iss5_llrdy", ll_wb_ready, 1'b1);

      // RAW on x5 stalls decode
      next_cycle();
      dec_valid = 1'b1; dec_rs1_addr = 5'd5;
      sample_port("raw5");
      check("raw5_busy", dbg_busy, 32'h0000_0020);
      check("raw5_stall", hazard_stall, 1'b1);

      // issue ll to x7
      next_cycle();
      ll_issue_valid = 1'b1; ll_issue_rd = 5'd7;
      sample_port("iss7");
      check("iss7_ready", ll_issue_ready, 1'b1);

      // WAW: x7 already busy, decode rd=7 stalls too
      next_cycle();
      ll_issue_valid = 1'b1; ll_issue_rd = 5'd7;
      dec_valid = 1'b1; dec_rd_addr = 5'd7;
      sample_port("waw7");
      check("waw7_ready", ll_issue_ready, 1'b0);
      check("waw7_stall", hazard_stall, 1'b1);
      check("waw7_busy", dbg_busy, 32'h0000_00A0);

      // ex rd=3 vs ll rd=4 every cycle: four blocked cycles, then starve
      for (int c = 1; c <= 4; c++) begin
         next_cycle();
         ex_wb_valid = 1'b1; ex_wb_rd = 5'd3; ex_wb_data = 32'hA000_0000 + c;
         ll_wb_valid = 1'b1; ll_wb_rd = 5'd4; ll_wb_data = 32'hBBBB_0004;
         expect_write(5'd3, 32'hA000_0000 + c);
         sample_port("arb_ex");
         check("arb_llrdy", ll_wb_ready, 1'b0);
         check("arb_hold", ex_hold, 1'b0);
         check("arb_wait", dbg_wait_cnt, WAIT_W'(c - 1));
         check("arb_busy", dbg_busy, 32'h0000_00A0);
      end
      // cycle 5: starve slot, ll owns the port, ex ignored
      next_cycle();
      ex_wb_valid = 1'b1; ex_wb_rd = 5'd3; ex_wb_data = 32'hA000_0005;
      ll_wb_valid = 1'b1; ll_wb_rd = 5'd4; ll_wb_data = 32'hBBBB_0004;
      expect_write(5'd4, 32'hBBBB_0004);
      sample_port("starve");
      check("starve_hold", ex_hold, 1'b1);
      check("starve_state", dbg_state, 1'b1);
      check("starve_llrdy", ll_wb_ready, 1'b1);
      // cycle 6: back to normal, ex re-presented and written
      next_cycle();
      ex_wb_valid = 1'b1; ex_wb_rd = 5'd3; ex_wb_data = 32'hA000_0005;
      expect_write(5'd3, 32'hA000_0005);
      sample_port("post_starve");
      check("post_hold", ex_hold, 1'b0);
      check("post_state", dbg_state, 1'b0);
      check("post_wait", dbg_wait_cnt, 3'd0);

      // ex to x0 yields to ll rd=9
      next_cycle();
      ex_wb_valid = 1'b1; ex_wb_rd = 5'd0; ex_wb_data = 32'hDEAD_BEEF;
      ll_wb_valid = 1'b1; ll_wb_rd = 5'd9; ll_wb_data = 32'h0000_0909;
      expect_write(5'd9, 32'h0000_0909);
      sample_port("ex_x0");
      check("ex_x0_llrdy", ll_wb_ready, 1'b1);

      // ll completes x5 while decode reads x5
      next_cycle();
      check("x0_wait", dbg_wait_cnt, 3'd0);
      ll_wb_valid = 1'b1; ll_wb_rd = 5'd5; ll_wb_data = 32'h5555_0005;
      dec_valid = 1'b1; dec_rs1_addr = 5'd5;
      expect_write(5'd5, 32'h5555_0005);
      sample_port("cmp5");
`ifdef RF_WB_BYPASS_EN
      check("cmp5_stall", hazard_stall, 1'b0);
`else
      check("cmp5_stall", hazard_stall, 1'b1);
`endif

      // one cycle later busy[5] is clear
      next_cycle();
      dec_valid = 1'b1; dec_rs1_addr = 5'd5; dec_rs2_addr = 5'd9;
      sample_port("after5");
      check("after5_stall", hazard_stall, 1'b0);
      check("after5_busy", dbg_busy, 32'h0000_0080);

      // issue x7 while x7 completes: issue refused, busy[7] clears
      next_cycle();
      ll_issue_valid = 1'b1; ll_issue_rd = 5'd7;
      ll_wb_valid = 1'b1; ll_wb_rd = 5'd7; ll_wb_data = 32'h7777_0007;
      expect_write(5'd7, 32'h7777_0007);
      sample_port("iss_cmp7");
      check("iss_cmp7_ready", ll_issue_ready, 1'b0);

      // ll result to x0: handshake without a write
      next_cycle();
      check("x7_clear_busy", dbg_busy, 32'h0);
      ll_wb_valid = 1'b1; ll_wb_rd = 5'd0; ll_wb_data = 32'h1234_5678;
      sample_port("ll_x0");
      check("ll_x0_llrdy", ll_wb_ready, 1'b1);

      // random ex-only writebacks
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         r = 5'($urandom_range(1, 31));
         d = $urandom;
         ex_wb_valid = 1'b1; ex_wb_rd = r; ex_wb_data = d;
         expect_write(r, d);
         sample_port("rand_ex");
      end

      // mid-run reset with x5 busy
      next_cycle();
      ll_issue_valid = 1'b1; ll_issue_rd = 5'd5;
      sample_port("iss5b");
      next_cycle();
      check("pre_rst_busy", dbg_busy, 32'h0000_0020);
      rst = 1'b1;
      dec_valid = 1'b1; dec_rs1_addr = 5'd5;
      ll_issue_valid = 1'b1; ll_issue_rd = 5'd6;
      ll_wb_valid = 1'b1; ll_wb_rd = 5'd4; ll_wb_data = 32'h4444_4444;
      ex_wb_valid = 1'b1; ex_wb_rd = 5'd3; ex_wb_data = 32'h3333_3333;
      sample_port("in_rst");
      check("in_rst_busy", dbg_busy, 32'h0);
      check("in_rst_hold", ex_hold, 1'b0);
      check("in_rst_stall", hazard_stall, 1'b0);
      check("in_rst_issrdy", ll_issue_ready, 1'b0);
      check("in_rst_llrdy", ll_wb_ready, 1'b0);
      next_cycle();
      rst = 1'b0;
      dec_valid = 1'b1; dec_rs1_addr = 5'd5;
      sample_port("post_rst");
      check("post_rst_stall", hazard_stall, 1'b0);
      check("post_rst_busy", dbg_busy, 32'h0);

      check("sb_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
